// File: rtl/fp_divider.sv
// IEEE-754 single-precision divider: restoring significand division, ITER_PER_CYCLE quotient bits per clock.
// Optional macro FP_DIV_ROUND_EN enables round-to-nearest-even; the default build truncates.
//
// state     | meaning
// IDLE      | waiting for operands, in_ready high
// DIVIDE    | resolving 26 quotient bits (24 mantissa, guard, round)
// NORMALIZE | rounding, overflow/underflow and special-case resolution
// DONE      | y valid, held until out_ready

module fp_divider #(
    parameter int ITER_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] y
);

    localparam int         STEPS    = (26 + ITER_PER_CYCLE - 1) / ITER_PER_CYCLE;
    localparam logic [4:0] CNT_LOAD = 5'(STEPS - 1);

    typedef enum logic [1:0] {IDLE, DIVIDE, NORMALIZE, DONE} state_t;

    state_t             state;
    state_t             state_nxt;
    logic               accept;

    logic [4:0]         cnt;
    logic [25:0]        rem;
    logic [25:0]        rem_nxt;
    logic [24:0]        quot;
    logic [24:0]        quot_nxt;
    logic [23:0]        mb;
    logic signed [9:0]  exp_q;
    logic               sign_q;
    logic               special_q;
    logic [31:0]        special_y;

    logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [23:0]        ma_in, mb_in;
    logic               lt_in;
    logic               sign_in;
    logic               spec_in;
    logic [31:0]        spec_y_in;
    logic signed [9:0]  exp_in;

    logic signed [9:0]  exp_fin;
    logic [22:0]        frac_fin;
    logic [31:0]        y_nxt;

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (accept) state_nxt = DIVIDE;
            DIVIDE:    if (cnt == 5'd0) state_nxt = NORMALIZE;
            NORMALIZE: state_nxt = DONE;
            DONE:      if (out_ready) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Operand classification; zero exponent field flushes the operand to zero.
    always_comb begin
        a_zero  = (a[30:23] == 8'h00);
        b_zero  = (b[30:23] == 8'h00);
        a_inf   = (a[30:23] == 8'hFF) && (a[22:0] == 23'h0);
        b_inf   = (b[30:23] == 8'hFF) && (b[22:0] == 23'h0);
        a_nan   = (a[30:23] == 8'hFF) && (a[22:0] != 23'h0);
        b_nan   = (b[30:23] == 8'hFF) && (b[22:0] != 23'h0);
        ma_in   = {1'b1, a[22:0]};
        mb_in   = {1'b1, b[22:0]};
        lt_in   = (ma_in < mb_in);
        sign_in = a[31] ^ b[31];
        exp_in  = $signed({2'b00, a[30:23]}) - $signed({2'b00, b[30:23]}) + 10'sd127
                  - (lt_in ? 10'sd1 : 10'sd0);

        spec_in   = 1'b1;
        spec_y_in = {sign_in, 8'hFF, 23'h400000};
        if (a_nan || b_nan)          spec_y_in = {sign_in, 8'hFF, 23'h400000};
        else if (a_zero && b_zero)   spec_y_in = {sign_in, 8'hFF, 23'h400000};
        else if (a_inf && b_inf)     spec_y_in = {sign_in, 8'hFF, 23'h400000};
        else if (a_inf)              spec_y_in = {sign_in, 8'hFF, 23'h0};
        else if (b_inf)              spec_y_in = {sign_in, 8'h00, 23'h0};
        else if (a_zero)             spec_y_in = {sign_in, 8'h00, 23'h0};
        else if (b_zero)             spec_y_in = {sign_in, 8'hFF, 23'h0};
        else begin
            spec_in   = 1'b0;
            spec_y_in = 32'h0;
        end
    end

    // Restoring division; the leading quotient bit falls off the top of quot.
    always_comb begin
        rem_nxt  = rem;
        quot_nxt = quot;
        for (int i = 0; i < ITER_PER_CYCLE; i++) begin
            if (rem_nxt >= {2'b00, mb}) begin
                quot_nxt = {quot_nxt[23:0], 1'b1};
                rem_nxt  = (rem_nxt - {2'b00, mb}) << 1;
            end else begin
                quot_nxt = {quot_nxt[23:0], 1'b0};
                rem_nxt  = rem_nxt << 1;
            end
        end
    end

`ifdef FP_DIV_ROUND_EN
    logic        round_up;
    logic [23:0] mant_rnd;

    always_comb begin
        round_up = quot[1] & (quot[0] | (|rem) | quot[2]);
        mant_rnd = {1'b0, quot[24:2]} + {23'h0, round_up};
        frac_fin = mant_rnd[23] ? 23'h0 : mant_rnd[22:0];
        exp_fin  = exp_q + (mant_rnd[23] ? 10'sd1 : 10'sd0);
    end
`else
    always_comb begin
        frac_fin = quot[24:2];
        exp_fin  = exp_q;
    end
`endif

    always_comb begin
        if (special_q)                 y_nxt = special_y;
        else if (exp_fin >= 10'sd255)  y_nxt = {sign_q, 8'hFF, 23'h0};
        else if (exp_fin <= 10'sd0)    y_nxt = {sign_q, 8'h00, 23'h0};
        else                           y_nxt = {sign_q, exp_fin[7:0], frac_fin};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= 5'd0;
            rem       <= 26'h0;
            quot      <= 25'h0;
            mb        <= 24'h0;
            exp_q     <= 10'sd0;
            sign_q    <= 1'b0;
            special_q <= 1'b0;
            special_y <= 32'h0;
            y         <= 32'h0;
        end else if (accept) begin
            cnt       <= CNT_LOAD;
            rem       <= lt_in ? {1'b0, ma_in, 1'b0} : {2'b00, ma_in};
            quot      <= 25'h0;
            mb        <= mb_in;
            exp_q     <= exp_in;
            sign_q    <= sign_in;
            special_q <= spec_in;
            special_y <= spec_y_in;
        end else if (state == DIVIDE) begin
            rem  <= rem_nxt;
            quot <= quot_nxt;
            if (cnt != 5'd0) cnt <= cnt - 5'd1;
        end else if (state == NORMALIZE) begin
            y <= y_nxt;
        end
    end

endmodule

// File: tb/tb_fp_divider.sv
// Directed-vector bench for fp_divider with ITER_PER_CYCLE=1; expectations are hand-computed.

module tb_fp_divider;

    localparam int ITER = 1;
    localparam int LAT  = (ITER == 1) ? 28 : 15;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] y;

    int n_vec = 0;
    int n_err = 0;

    fp_divider #(.ITER_PER_CYCLE(ITER)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [31:0] op_a, input logic [31:0] op_b);
        @(negedge clk);
        check("rdy_before", 32'(in_ready), 32'h1);
        in_valid = 1'b1;
        a        = op_a;
        b        = op_b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
    endtask

    // Cycle 1 is the cycle right after the accepting edge.
    task automatic wait_result(input string tag, input logic [31:0] exp_y);
        int lat;
        lat = 0;
        while (lat < 80) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
        end
        check({tag, "_lat"}, 32'(lat), 32'(LAT));
        check({tag, "_y"}, y, exp_y);
    endtask

    task automatic release_result(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check({tag, "_rdy_after"}, 32'({in_ready, out_valid}), 32'h2);
    endtask

    task automatic run_op(input string tag, input logic [31:0] op_a, input logic [31:0] op_b,
                          input logic [31:0] exp_y);
        issue(op_a, op_b);
        wait_result(tag, exp_y);
        release_result(tag);
    endtask

    initial begin
        logic [31:0] y_hold;
        logic        seen;

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 32'h0;
        b         = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'h1);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_y", y, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        run_op("six_div_two", 32'h40C00000, 32'h40000000, 32'h40400000);
`ifdef FP_DIV_ROUND_EN
        run_op("one_third", 32'h3F800000, 32'h40400000, 32'h3EAAAAAB);
`else
        run_op("one_third", 32'h3F800000, 32'h40400000, 32'h3EAAAAAA);
`endif
        run_op("seven_div_two", 32'h40E00000, 32'h40000000, 32'h40600000);
        run_op("neg_six_div_two", 32'hC0C00000, 32'h40000000, 32'hC0400000);
        run_op("one_div_zero", 32'h3F800000, 32'h00000000, 32'h7F800000);
        run_op("zero_div_zero", 32'h00000000, 32'h00000000, 32'h7FC00000);
        run_op("ninf_div_one", 32'hFF800000, 32'h3F800000, 32'hFF800000);
        run_op("inf_div_ninf", 32'h7F800000, 32'hFF800000, 32'hFFC00000);
        run_op("nan_div_one", 32'h7FC00000, 32'h3F800000, 32'h7FC00000);
        run_op("one_div_inf", 32'h3F800000, 32'h7F800000, 32'h00000000);
        run_op("overflow", 32'h7F000000, 32'h00800000, 32'h7F800000);
        run_op("underflow", 32'h00800000, 32'h7F000000, 32'h00000000);

        // Backpressure: result must sit unchanged while out_ready stays low.
        issue(32'h40C00000, 32'h40000000);
        wait_result("hold", 32'h40400000);
        y_hold = y;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_y", y, y_hold);
            check("hold_valid", 32'(out_valid), 32'h1);
            check("hold_in_ready", 32'(in_ready), 32'h0);
        end
        release_result("hold");

        // Reset at cycle 10 of a divide must discard the operation.
        issue(32'h40C00000, 32'h40000000);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("midrst_in_ready", 32'(in_ready), 32'h1);
        check("midrst_y", y, 32'h0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("midrst_no_result", 32'(seen), 32'h0);
        run_op("after_reset", 32'h40C00000, 32'h40000000, 32'h40400000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
